// File: rtl/id_hazard_ctrl.sv
// Hazard detection and flush sequencing for the ID stage of the five-stage core.
// Drives freeze/flush controls combinationally and keeps saturating stall/flush counters.
module id_hazard_ctrl #(
  parameter int unsigned BRANCH_SHADOW = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forwardEn,
  input  logic [3:0]       src1,
  input  logic             src1Valid,
  input  logic [3:0]       src2,
  input  logic             src2Valid,
  input  logic [3:0]       exeDest,
  input  logic             exeWriteBackEn,
  input  logic             exeMemRead,
  input  logic [3:0]       memDest,
  input  logic             memWriteBackEn,
  input  logic             branchTaken,
  input  logic             cntClear,
  output logic             freeze,
  output logic             flushIFID,
  output logic             flushIDEXE,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             shadowActive
);

  typedef enum logic {StRun, StShadow} state_e;

  localparam logic [3:0] ShadowReload = (BRANCH_SHADOW > 1) ? 4'(BRANCH_SHADOW - 2) : 4'd0;

  state_e           state_q;
  logic [3:0]       shadow_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic exe_match;
  logic mem_match;
  logic hazard;

  always_comb begin
    exe_match = (src1Valid && (src1 == exeDest)) || (src2Valid && (src2 == exeDest));
    mem_match = (src1Valid && (src1 == memDest)) || (src2Valid && (src2 == memDest));
    if (forwardEn) begin
      // Forwarding covers everything except a load result not yet read from memory.
      hazard = exe_match && exeWriteBackEn && exeMemRead;
    end else begin
      hazard = (exe_match && exeWriteBackEn) || (mem_match && memWriteBackEn);
    end
  end

  always_comb begin
    freeze     = 1'b0;
    flushIFID  = 1'b0;
    flushIDEXE = 1'b0;
    if (rst) begin
      if (branchTaken || (state_q == StShadow)) begin
        flushIFID  = 1'b1;
        flushIDEXE = 1'b1;
      end else if (hazard) begin
        freeze     = 1'b1;
        flushIDEXE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      shadow_cnt_q <= 4'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branchTaken && (BRANCH_SHADOW > 1)) begin
            state_q      <= StShadow;
            shadow_cnt_q <= ShadowReload;
          end
        end
        StShadow: begin
          if (branchTaken) begin
            shadow_cnt_q <= ShadowReload;
          end else if (shadow_cnt_q == 4'd0) begin
            state_q <= StRun;
          end else begin
            shadow_cnt_q <= shadow_cnt_q - 4'd1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (cntClear) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flushIFID && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stallCount   = stall_cnt_q;
  assign flushCount   = flush_cnt_q;
  assign shadowActive = rst && (state_q == StShadow);

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: combinational vector table plus multi-cycle
// branch-shadow, saturation and reset sequences.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        forwardEn;
  logic [3:0]  src1, src2, exeDest, memDest;
  logic        src1Valid, src2Valid, exeWriteBackEn, exeMemRead, memWriteBackEn;
  logic        branchTaken, cntClear;
  logic        freeze, flushIFID, flushIDEXE, shadowActive;
  logic [15:0] stallCount, flushCount;

  int checks = 0;
  int errors = 0;

  id_hazard_ctrl #(.BRANCH_SHADOW(3), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .forwardEn     (forwardEn),
    .src1          (src1),
    .src1Valid     (src1Valid),
    .src2          (src2),
    .src2Valid     (src2Valid),
    .exeDest       (exeDest),
    .exeWriteBackEn(exeWriteBackEn),
    .exeMemRead    (exeMemRead),
    .memDest       (memDest),
    .memWriteBackEn(memWriteBackEn),
    .branchTaken   (branchTaken),
    .cntClear      (cntClear),
    .freeze        (freeze),
    .flushIFID     (flushIFID),
    .flushIDEXE    (flushIDEXE),
    .stallCount    (stallCount),
    .flushCount    (flushCount),
    .shadowActive  (shadowActive)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fwd;
    logic [3:0] s1;
    logic       s1v;
    logic [3:0] s2;
    logic       s2v;
    logic [3:0] ed;
    logic       ewb;
    logic       emr;
    logic [3:0] md;
    logic       mwb;
    logic       exp_freeze;
    logic       exp_fifid;
    logic       exp_fidexe;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string name, input logic fz, input logic fi, input logic fe);
    check({name, ".freeze"}, 32'(freeze), 32'(fz));
    check({name, ".flushIFID"}, 32'(flushIFID), 32'(fi));
    check({name, ".flushIDEXE"}, 32'(flushIDEXE), 32'(fe));
  endtask

  task automatic idle_inputs();
    forwardEn = 1'b0; src1 = 4'd0; src1Valid = 1'b0; src2 = 4'd0; src2Valid = 1'b0;
    exeDest = 4'd0; exeWriteBackEn = 1'b0; exeMemRead = 1'b0;
    memDest = 4'd0; memWriteBackEn = 1'b0; branchTaken = 1'b0; cntClear = 1'b0;
  endtask

  task automatic set_hazard();
    forwardEn = 1'b0; src1 = 4'd3; src1Valid = 1'b1; exeDest = 4'd3; exeWriteBackEn = 1'b1;
  endtask

  task automatic clear_counters();
    @(negedge clk);
    idle_inputs();
    cntClear = 1'b1;
    @(negedge clk);
    cntClear = 1'b0;
  endtask

  initial begin
    //         fwd s1    v  s2     v  ed     ewb emr md    mwb  fz fi fe
    tv[0]  = '{0, 4'd3, 1, 4'd0,  0, 4'd3,  1, 0, 4'd0, 0,   1, 0, 1};
    tv[1]  = '{1, 4'd3, 1, 4'd0,  0, 4'd3,  1, 0, 4'd0, 0,   0, 0, 0};
    tv[2]  = '{1, 4'd3, 1, 4'd0,  0, 4'd3,  1, 1, 4'd0, 0,   1, 0, 1};
    tv[3]  = '{1, 4'd3, 1, 4'd0,  0, 4'd7,  0, 0, 4'd3, 1,   0, 0, 0};
    tv[4]  = '{0, 4'd3, 1, 4'd0,  0, 4'd7,  0, 0, 4'd3, 1,   1, 0, 1};
    tv[5]  = '{0, 4'd3, 0, 4'd0,  0, 4'd3,  1, 0, 4'd3, 1,   0, 0, 0};
    tv[6]  = '{0, 4'd0, 0, 4'd15, 1, 4'd15, 1, 0, 4'd0, 0,   1, 0, 1};
    tv[7]  = '{0, 4'd2, 1, 4'd4,  1, 4'd3,  1, 0, 4'd5, 1,   0, 0, 0};
    tv[8]  = '{0, 4'd3, 1, 4'd0,  0, 4'd3,  0, 0, 4'd0, 0,   0, 0, 0};
    tv[9]  = '{1, 4'd0, 0, 4'd9,  1, 4'd9,  1, 1, 4'd0, 0,   1, 0, 1};
    tv[10] = '{1, 4'd3, 1, 4'd0,  0, 4'd3,  0, 1, 4'd0, 0,   0, 0, 0};

    // Reset held: outputs forced low even with a branch and a hazard present.
    idle_inputs();
    set_hazard();
    branchTaken = 1'b1;
    rst = 1'b0;
    #12;
    check_ctrl("reset", 0, 0, 0);
    check("reset.shadowActive", 32'(shadowActive), 0);
    check("reset.stallCount", 32'(stallCount), 0);
    check("reset.flushCount", 32'(flushCount), 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // Combinational vector table; cntClear keeps counters at zero meanwhile.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle_inputs();
      cntClear = 1'b1;
      forwardEn = tv[i].fwd; src1 = tv[i].s1; src1Valid = tv[i].s1v;
      src2 = tv[i].s2; src2Valid = tv[i].s2v; exeDest = tv[i].ed;
      exeWriteBackEn = tv[i].ewb; exeMemRead = tv[i].emr;
      memDest = tv[i].md; memWriteBackEn = tv[i].mwb;
      #1;
      check_ctrl($sformatf("vec%0d", i), tv[i].exp_freeze, tv[i].exp_fifid, tv[i].exp_fidexe);
    end

    // One stall cycle increments stallCount once.
    clear_counters();
    set_hazard();
    #1;
    check("stall.pre", 32'(stallCount), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("stall.post", 32'(stallCount), 1);
    check_ctrl("stall.after", 0, 0, 0);

    // Branch with hazard present: three flush cycles, shadow on cycles 2-3.
    clear_counters();
    set_hazard();
    branchTaken = 1'b1;
    #1;
    check_ctrl("br1.c1", 0, 1, 1);
    check("br1.c1.shadow", 32'(shadowActive), 0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      branchTaken = 1'b0;
      #1;
      check_ctrl($sformatf("br1.c%0d", c), 0, 1, 1);
      check($sformatf("br1.c%0d.shadow", c), 32'(shadowActive), 1);
    end
    @(negedge clk);
    #1;
    check_ctrl("br1.c4", 1, 0, 1);
    check("br1.c4.shadow", 32'(shadowActive), 0);
    check("br1.flushCount", 32'(flushCount), 3);
    check("br1.stallCount", 32'(stallCount), 0);

    // Second branch in the last shadow cycle extends flushing to five cycles.
    clear_counters();
    for (int c = 1; c <= 6; c++) begin
      branchTaken = (c == 1 || c == 3);
      #1;
      check($sformatf("br2.c%0d.flush", c), 32'(flushIFID), (c <= 5) ? 1 : 0);
      check($sformatf("br2.c%0d.shadow", c), 32'(shadowActive), (c >= 2 && c <= 5) ? 1 : 0);
      @(negedge clk);
    end
    branchTaken = 1'b0;
    #1;
    check("br2.flushCount", 32'(flushCount), 5);

    // Saturation of stallCount, then clear while hazard is still present.
    clear_counters();
    set_hazard();
    repeat (65534) @(negedge clk);
    #1;
    check("sat.fffe", 32'(stallCount), 32'hFFFE);
    @(negedge clk);
    #1;
    check("sat.ffff", 32'(stallCount), 32'hFFFF);
    repeat (2) @(negedge clk);
    #1;
    check("sat.hold", 32'(stallCount), 32'hFFFF);
    cntClear = 1'b1;
    @(negedge clk);
    cntClear = 1'b0;
    #1;
    check("sat.clear", 32'(stallCount), 0);

    // Reset in the middle of a shadow.
    idle_inputs();
    branchTaken = 1'b1;
    @(negedge clk);
    branchTaken = 1'b0;
    #1;
    check("rstsh.shadow", 32'(shadowActive), 1);
    rst = 1'b0;
    #1;
    check_ctrl("rstsh.inrst", 0, 0, 0);
    check("rstsh.inrst.shadow", 32'(shadowActive), 0);
    check("rstsh.inrst.flushCount", 32'(flushCount), 0);
    check("rstsh.inrst.stallCount", 32'(stallCount), 0);
    @(negedge clk);
    rst = 1'b1;
    src2 = 4'd5; src2Valid = 1'b1; src1Valid = 1'b0; exeDest = 4'd5; exeWriteBackEn = 1'b1;
    #1;
    check_ctrl("rstsh.src2", 1, 0, 1);
    check("rstsh.run", 32'(shadowActive), 0);
    src2Valid = 1'b0;
    #1;
    check_ctrl("rstsh.src2inv", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
